// File: rtl/complex_div_if.sv
// Operand/result bundle for the sequential complex divider.
// The requester drives the master side, the divider sits on the slave side.
interface complex_div_if #(
  parameter int QI = 3,
  parameter int QF = 3
);
  localparam int W  = QI + QF;
  localparam int WO = 2*W + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  a_Re, a_Im, b_Re, b_Im;
  logic                 out_valid;
  logic signed [WO-1:0] y_Re, y_Im;
  logic                 div0;
  logic                 ovf;

  modport master (
    output in_valid, a_Re, a_Im, b_Re, b_Im,
    input  in_ready, out_valid, y_Re, y_Im, div0, ovf
  );

  modport slave (
    input  in_valid, a_Re, a_Im, b_Re, b_Im,
    output in_ready, out_valid, y_Re, y_Im, div0, ovf
  );
endinterface

// File: rtl/complex_div.sv
// Sequential fixed-point complex divider, y = a / b.
// Forms conj(b)*a and |b|^2 once, then runs two restoring dividers
// (real and imaginary lanes) that share the denominator and retire one
// quotient bit per clock. Magnitudes are truncated, sign applied last,
// and saturation is symmetric.
module complex_div #(
  parameter int QI = 3,
  parameter int QF = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  complex_div_if.slave io
);
  localparam int W    = QI + QF;
  localparam int WO   = 2*W + 1;
  localparam int MW   = 2*W + 1;       // exact numerator / denominator width
  localparam int DW   = MW + 2*QF;     // dividend after fractional pre-shift
  localparam int RW   = MW + 1;        // trial remainder width
  localparam int CW   = MW + 2*W;      // width of the saturation compare
  localparam int CNTW = $clog2(2*W);
  localparam logic [CNTW-1:0] LAST = CNTW'(2*W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
  state_t state, nstate;

  logic signed [W-1:0]  ar, ai, br, bi;
  logic [MW-1:0]        den, den_c;
  logic                 dz;
  logic [CNTW-1:0]      cnt;
  logic signed [MW-1:0] nre, nim;
  logic [1:0][MW-1:0]   nsv, mag, rem;
  logic [1:0][DW-1:0]   dv;
  logic [1:0][RW-1:0]   trial;
  logic [1:0][2*W-1:0]  lo, q, mag_o;
  logic [1:0][WO-1:0]   y_n;
  logic [1:0]           neg, sat_c, ge, sat, sgn;

  function automatic logic signed [MW-1:0] sx(input logic signed [W-1:0] v);
    return MW'(v);
  endfunction

  // conj(b)*a and |b|^2, exact at MW bits
  assign nre    = sx(ar)*sx(br) + sx(ai)*sx(bi);
  assign nim    = sx(ai)*sx(br) - sx(ar)*sx(bi);
  assign den_c  = MW'(sx(br)*sx(br) + sx(bi)*sx(bi));
  assign nsv[0] = nre;
  assign nsv[1] = nim;

  assign io.in_ready = (state == IDLE);

  for (genvar k = 0; k < 2; k++) begin : g_lane
    assign neg[k]   = nsv[k][MW-1];
    assign mag[k]   = neg[k] ? (~nsv[k]) + MW'(1) : nsv[k];
    assign dv[k]    = {mag[k], {(2*QF){1'b0}}};
    // quotient would need more than 2W bits
    assign sat_c[k] = CW'(dv[k]) >= (CW'(den_c) << (2*W));
    // remainder stays below den, so its shifted value fits RW bits
    assign trial[k] = {rem[k], lo[k][2*W-1]};
    assign ge[k]    = trial[k] >= {1'b0, den};
    assign mag_o[k] = sat[k] ? '1 : q[k];
    assign y_n[k]   = sgn[k] ? (~{1'b0, mag_o[k]}) + WO'(1) : {1'b0, mag_o[k]};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // next-state: IDLE -> LOAD -> DIV (2W cycles) -> DONE -> IDLE
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (io.in_valid) nstate = LOAD;
      LOAD: nstate = DIV;
      DIV:  if (cnt == LAST) nstate = DONE;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // operand capture, divider iterations and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar <= '0; ai <= '0; br <= '0; bi <= '0;
      den <= '0; dz <= 1'b0; cnt <= '0;
      rem <= '0; lo <= '0; q <= '0; sat <= '0; sgn <= '0;
      io.out_valid <= 1'b0;
      io.y_Re <= '0; io.y_Im <= '0;
      io.div0 <= 1'b0; io.ovf <= 1'b0;
    end else begin
      io.out_valid <= 1'b0;
      case (state)
        IDLE: if (io.in_valid) begin
          ar <= io.a_Re; ai <= io.a_Im;
          br <= io.b_Re; bi <= io.b_Im;
        end
        LOAD: begin
          den <= den_c;
          dz  <= (den_c == '0);
          cnt <= '0;
          for (int k = 0; k < 2; k++) begin
            sgn[k] <= neg[k];
            sat[k] <= sat_c[k];
            rem[k] <= MW'(dv[k] >> (2*W));
            lo[k]  <= dv[k][2*W-1:0];
            q[k]   <= '0;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          for (int k = 0; k < 2; k++) begin
            rem[k] <= ge[k] ? MW'(trial[k] - {1'b0, den}) : MW'(trial[k]);
            lo[k]  <= {lo[k][2*W-2:0], 1'b0};
            q[k]   <= {q[k][2*W-2:0], ge[k]};
          end
        end
        DONE: begin
          io.out_valid <= 1'b1;
          io.div0      <= dz;
          io.ovf       <= ~dz & (|sat);
          io.y_Re      <= dz ? '0 : y_n[0];
          io.y_Im      <= dz ? '0 : y_n[1];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_div.sv
// Bench for complex_div: directed and random divisions against a
// scoreboard, back-to-back handshake, mid-operation reset, and a
// saturating build (QI=2, QF=4).
module tb_complex_div;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  complex_div_if #(.QI(3), .QF(3)) io0 ();
  complex_div_if #(.QI(2), .QF(4)) io1 ();

  complex_div #(.QI(3), .QF(3)) dut0 (.clk(clk), .rst_n(rst_n), .io(io0));
  complex_div #(.QI(2), .QF(4)) dut1 (.clk(clk), .rst_n(rst_n), .io(io1));

  typedef struct {
    longint yr;
    longint yi;
    logic   dz;
    logic   ov;
    int     t;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   nchk = 0;
  int   npass = 0;
  int   cyc = 0;
  int   pulses0 = 0;
  int   last_t = 0;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    nchk++;
    assert (obs === expv) begin
      npass++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input longint yr,
                     input longint yi, input logic dz, input logic ov);
    chk({who, "_y_re"}, yr, e.yr);
    chk({who, "_y_im"}, yi, e.yi);
    chk({who, "_div0"}, dz, e.dz);
    chk({who, "_ovf"}, ov, e.ov);
    chk({who, "_latency"}, cyc - e.t, 14);
  endtask

  function automatic bit issat(longint n, longint den, int qf, int w);
    longint m = (n < 0) ? -n : n;
    return (m << (2*qf)) >= (den << (2*w));
  endfunction

  function automatic longint comp(longint n, longint den, int qf, int w);
    longint m  = (n < 0) ? -n : n;
    longint mg = issat(n, den, qf, w) ? (longint'(1) << (2*w)) - 1
                                      : (m << (2*qf)) / den;
    return (n < 0) ? -mg : mg;
  endfunction

  function automatic exp_t model(int qf, int w, longint ar, longint ai,
                                 longint br, longint bi);
    exp_t   e;
    longint nr  = ar*br + ai*bi;
    longint ni  = ai*br - ar*bi;
    longint den = br*br + bi*bi;
    e.t = 0;
    if (den == 0) begin
      e.yr = 0; e.yi = 0; e.dz = 1'b1; e.ov = 1'b0;
    end else begin
      e.yr = comp(nr, den, qf, w);
      e.yi = comp(ni, den, qf, w);
      e.dz = 1'b0;
      e.ov = issat(nr, den, qf, w) | issat(ni, den, qf, w);
    end
    return e;
  endfunction

  // called at a negedge; returns at the negedge after the transfer
  task automatic op0(input int ar, input int ai, input int br, input int bi,
                     input exp_t e, input bit hold);
    int n = 0;
    io0.a_Re = 6'(ar); io0.a_Im = 6'(ai);
    io0.b_Re = 6'(br); io0.b_Im = 6'(bi);
    io0.in_valid = 1'b1;
    while (!io0.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!io0.in_ready) begin
      nchk++;
      $error("FAIL handshake_timeout: in_ready stuck at %0b, need 1", io0.in_ready);
    end else begin
      e.t = cyc + 1;
      last_t = e.t;
      q0.push_back(e);
    end
    @(negedge clk);
    if (!hold) io0.in_valid = 1'b0;
  endtask

  function automatic exp_t mk(longint yr, longint yi, logic dz, logic ov);
    exp_t e;
    e.yr = yr; e.yi = yi; e.dz = dz; e.ov = ov; e.t = 0;
    return e;
  endfunction

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      nchk++;
      $error("FAIL drain_timeout: %0d results outstanding, need 0", q0.size() + q1.size());
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // result monitor, main build
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (io0.out_valid) begin
        pulses0++;
        chk("single_cycle", prev0, 1'b0);
        if (q0.size() == 0) begin
          nchk++;
          $error("FAIL unexpected_out_valid: got 1 with no request outstanding, need 0");
        end else begin
          e = q0.pop_front();
          cmp("d0", e, io0.y_Re, io0.y_Im, io0.div0, io0.ovf);
        end
      end
      prev0 = io0.out_valid;
    end
  end

  // result monitor, saturating build
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (io1.out_valid) begin
        chk("d1_single_cycle", prev1, 1'b0);
        if (q1.size() == 0) begin
          nchk++;
          $error("FAIL d1_unexpected_out_valid: got 1 with no request outstanding, need 0");
        end else begin
          e = q1.pop_front();
          cmp("d1", e, io1.y_Re, io1.y_Im, io1.div0, io1.ovf);
        end
      end
      prev1 = io1.out_valid;
    end
  end

  initial begin
    int t1;
    int p;
    int r[4];
    io0.in_valid = 1'b0;
    io0.a_Re = '0; io0.a_Im = '0; io0.b_Re = '0; io0.b_Im = '0;
    io1.in_valid = 1'b0;
    io1.a_Re = '0; io1.a_Im = '0; io1.b_Re = '0; io1.b_Im = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", io0.in_ready, 1'b1);
    chk("rst_out_valid", io0.out_valid, 1'b0);
    chk("rst_y_re", io0.y_Re, 0);
    chk("rst_y_im", io0.y_Im, 0);
    chk("rst_div0", io0.div0, 1'b0);
    chk("rst_ovf", io0.ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    op0(8, 0, 16, 0, mk(32, 0, 1'b0, 1'b0), 1'b0);
    drain();
    op0(8, 8, 8, -8, mk(0, 64, 1'b0, 1'b0), 1'b0);
    drain();
    op0(-8, 0, 24, 0, mk(-21, 0, 1'b0, 1'b0), 1'b0);
    drain();
    op0(8, 8, 0, 16, mk(32, -32, 1'b0, 1'b0), 1'b0);
    drain();
    op0(31, -32, 0, 0, mk(0, 0, 1'b1, 1'b0), 1'b0);
    drain();

    // random operands against the reference model
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) r[j] = int'($urandom_range(0, 63)) - 32;
      op0(r[0], r[1], r[2], r[3], model(3, 6, r[0], r[1], r[2], r[3]), 1'b0);
      drain();
    end

    // in_valid held high across three operations
    p = pulses0;
    op0(8, 0, 16, 0, mk(32, 0, 1'b0, 1'b0), 1'b1);
    t1 = last_t;
    chk("b2b_busy1", io0.in_ready, 1'b0);
    op0(8, 8, 8, -8, mk(0, 64, 1'b0, 1'b0), 1'b1);
    chk("b2b_spacing1", last_t - t1, 15);
    t1 = last_t;
    chk("b2b_busy2", io0.in_ready, 1'b0);
    op0(-8, 0, 24, 0, mk(-21, 0, 1'b0, 1'b0), 1'b0);
    chk("b2b_spacing2", last_t - t1, 15);
    drain();
    repeat (5) @(negedge clk);
    chk("b2b_pulses", pulses0 - p, 3);
    chk("hold_y_re", io0.y_Re, -21);

    // reset while dividing
    op0(8, 8, 0, 16, mk(32, -32, 1'b0, 1'b0), 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("abort_out_valid", io0.out_valid, 1'b0);
    chk("abort_y_re", io0.y_Re, 0);
    chk("abort_y_im", io0.y_Im, 0);
    chk("abort_in_ready", io0.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    op0(-8, 0, 24, 0, mk(-21, 0, 1'b0, 1'b0), 1'b0);
    drain();

    // saturating build: -2.0 / (1/16)
    io1.a_Re = -6'sd32; io1.a_Im = '0;
    io1.b_Re = 6'sd1;   io1.b_Im = '0;
    io1.in_valid = 1'b1;
    chk("d1_ready", io1.in_ready, 1'b1);
    q1.push_back('{yr: -4095, yi: 0, dz: 1'b0, ov: 1'b1, t: cyc + 1});
    @(negedge clk);
    io1.in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
